// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 64 lines of 4 x 32-bit words.
// Hits are served combinationally; misses stall, write back a dirty victim, then fill.
module cache_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_up,
    input  logic        read_up,
    input  logic        write_up,
    inout  wire  [31:0] data_up,
    output logic        stall_up,
    output logic [31:0] addr_mem,
    output logic        read_mem,
    output logic        write_mem,
    inout  wire  [31:0] data_mem,
    input  logic        ready_mem
);

    typedef enum logic [2:0] {
        StIdle,
        StWbReq,
        StWbXfer,
        StFillReq,
        StFillXfer
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [3:0][31:0]  r_data [64];
    logic [21:0]       r_tag  [64];
    logic [63:0]       r_valid;
    logic [63:0]       r_dirty;
    logic [1:0]        r_beat;
    logic [31:4]       r_maddr;

    logic [5:0]        w_up_index;
    logic [5:0]        w_m_index;
    logic [21:0]       w_victim_tag;
    logic              w_req;
    logic              w_hit;
    logic              w_up_oe;
    logic              w_mem_oe;
    logic              w_miss;
    logic              w_wr_hit;
    logic              w_wb_adv;
    logic              w_wb_done;
    logic              w_fill_we;
    logic              w_fill_done;
    logic              w_unused;

    assign w_unused     = ^addr_up[1:0];
    assign w_req        = read_up | write_up;
    assign w_up_index   = addr_up[9:4];
    // Transfers use the address latched at miss detection, so a dropped request still completes.
    assign w_m_index    = r_maddr[9:4];
    assign w_victim_tag = r_tag[w_m_index];
    assign w_hit        = r_valid[w_up_index] && (r_tag[w_up_index] == addr_up[31:10]);
    assign stall_up     = w_req && !((r_state == StIdle) && w_hit);

    assign data_up  = w_up_oe  ? r_data[w_up_index][addr_up[3:2]] : 'z;
    assign data_mem = w_mem_oe ? r_data[w_m_index][r_beat]        : 'z;

    always_comb begin
        w_state_next = r_state;
        read_mem     = 1'b0;
        write_mem    = 1'b0;
        addr_mem     = '0;
        w_up_oe      = 1'b0;
        w_mem_oe     = 1'b0;
        w_miss       = 1'b0;
        w_wr_hit     = 1'b0;
        w_wb_adv     = 1'b0;
        w_wb_done    = 1'b0;
        w_fill_we    = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (write_up) begin
                            w_wr_hit = 1'b1;
                        end else begin
                            w_up_oe = 1'b1;
                        end
                    end else begin
                        w_miss = 1'b1;
                        if (r_valid[w_up_index] && r_dirty[w_up_index]) begin
                            w_state_next = StWbReq;
                        end else begin
                            w_state_next = StFillReq;
                        end
                    end
                end
            end
            StWbReq: begin
                write_mem    = 1'b1;
                w_mem_oe     = 1'b1;
                addr_mem     = {w_victim_tag, w_m_index, 4'b0000};
                w_state_next = StWbXfer;
            end
            StWbXfer: begin
                write_mem = 1'b1;
                w_mem_oe  = 1'b1;
                addr_mem  = {w_victim_tag, w_m_index, r_beat, 2'b00};
                if (ready_mem) begin
                    w_wb_adv = 1'b1;
                    if (r_beat == 2'd3) begin
                        w_wb_done    = 1'b1;
                        w_state_next = StFillReq;
                    end
                end
            end
            StFillReq: begin
                read_mem     = 1'b1;
                addr_mem     = {r_maddr, 4'b0000};
                w_state_next = StFillXfer;
            end
            StFillXfer: begin
                read_mem = 1'b1;
                addr_mem = {r_maddr, r_beat, 2'b00};
                if (ready_mem) begin
                    w_fill_we = 1'b1;
                    if (r_beat == 2'd3) begin
                        w_fill_done  = 1'b1;
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // The beat counter wraps to 0 after each 4-beat phase, so REQ states always see beat 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_beat  <= '0;
            r_valid <= '0;
            r_dirty <= '0;
            r_maddr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_miss) begin
                r_maddr <= addr_up[31:4];
            end
            if (w_wb_adv || w_fill_we) begin
                r_beat <= r_beat + 2'd1;
            end
            if (w_wr_hit) begin
                r_dirty[w_up_index] <= 1'b1;
            end
            if (w_wb_done) begin
                r_dirty[w_m_index] <= 1'b0;
            end
            if (w_fill_done) begin
                r_valid[w_m_index] <= 1'b1;
                r_dirty[w_m_index] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            r_data[w_up_index][addr_up[3:2]] <= data_up;
        end
        if (w_fill_we) begin
            r_data[w_m_index][r_beat] <= data_mem;
        end
        if (w_fill_done) begin
            r_tag[w_m_index] <= r_maddr[31:10];
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed vector table, mid-fill reset,
// and random traffic checked against a processor-visible memory image.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr_up = '0;
    logic        read_up = 1'b0;
    logic        write_up = 1'b0;
    logic        ready_mem = 1'b0;
    logic        stall_up;
    logic        read_mem;
    logic        write_mem;
    logic [31:0] addr_mem;
    wire  [31:0] data_up;
    wire  [31:0] data_mem;

    logic        up_oe = 1'b0;
    logic [31:0] up_d = '0;
    logic [31:0] rd_val = '0;

    assign data_up  = up_oe ? up_d : 'z;
    assign data_mem = read_mem ? rd_val : 'z;

    cache_controller dut (
        .clk       (clk),
        .reset     (reset),
        .addr_up   (addr_up),
        .read_up   (read_up),
        .write_up  (write_up),
        .data_up   (data_up),
        .stall_up  (stall_up),
        .addr_mem  (addr_mem),
        .read_mem  (read_mem),
        .write_mem (write_mem),
        .data_mem  (data_mem),
        .ready_mem (ready_mem)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit aborted = 1'b0;

    // Main memory model and the value the processor should see at each word address.
    logic [31:0] mem    [int unsigned];
    logic [31:0] shadow [int unsigned];
    logic [31:0] wb_addr_q[$];
    logic [31:0] wb_data_q[$];
    logic [31:0] rd_addr_q[$];
    int          low_cycles = 0;
    int          mem_lat = 0;
    bit          rand_ready = 1'b0;

    function automatic logic [31:0] base_word(input logic [31:0] a);
        case (a)
            32'h4010: return 32'h0000;
            32'h4014: return 32'h1111;
            32'h4018: return 32'h2222;
            32'h401C: return 32'h3333;
            32'h0410: return 32'hAAAA;
            32'h0414: return 32'hBBBB;
            32'h0418: return 32'hCCCC;
            32'h041C: return 32'hDDDD;
            default:  return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return base_word(a);
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return base_word(a);
    endfunction

    // Memory responder: decides ready_mem for each cycle at the falling edge and commits the
    // beat that transferred at the rising edge in between. The first cycle of a phase is REQ.
    bit          pend_w = 1'b0;
    bit          pend_r = 1'b0;
    logic [31:0] pend_a = '0;
    logic [31:0] pend_d = '0;
    logic [1:0]  cur_phase = '0;
    logic [1:0]  prev_phase = '0;
    int          wait_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            pend_w     = 1'b0;
            pend_r     = 1'b0;
            prev_phase = '0;
            ready_mem  = 1'b0;
        end else begin
            if (pend_w) begin
                mem[pend_a] = pend_d;
                wb_addr_q.push_back(pend_a);
                wb_data_q.push_back(pend_d);
            end
            if (pend_r) rd_addr_q.push_back(pend_a);
            pend_w = 1'b0;
            pend_r = 1'b0;
            cur_phase = write_mem ? 2'd1 : (read_mem ? 2'd2 : 2'd0);
            if (cur_phase == 2'd0) begin
                ready_mem = 1'b0;
            end else if (cur_phase != prev_phase) begin
                wait_cnt  = mem_lat;
                ready_mem = 1'b0;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                ready_mem = 1'b0;
                low_cycles++;
            end else begin
                ready_mem = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (!ready_mem) low_cycles++;
            end
            if (cur_phase == 2'd2) rd_val = mem_rd(addr_mem);
            if (cur_phase != 2'd0 && cur_phase == prev_phase && ready_mem) begin
                pend_w = (cur_phase == 2'd1);
                pend_r = (cur_phase == 2'd2);
                pend_a = addr_mem;
                pend_d = data_mem;
            end
            prev_phase = cur_phase;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rdata, output int stalls, output int wb0,
                         output int rd0, output int low0);
        rdata  = '0;
        stalls = 0;
        @(negedge clk);
        #1;
        wb0      = wb_addr_q.size();
        rd0      = rd_addr_q.size();
        low0     = low_cycles;
        addr_up  = a;
        write_up = wr;
        read_up  = rd;
        up_oe    = wr;
        up_d     = wd;
        #2;
        while (stall_up && stalls < 300) begin
            stalls++;
            @(negedge clk);
            #3;
        end
        if (stall_up) begin
            n_tests++;
            n_fail++;
            aborted = 1'b1;
            $display("FAIL stall timeout: addr 0x%08h still stalled after %0d cycles", a, stalls);
        end else if (!wr) begin
            rdata = data_up;
        end
        @(negedge clk);
        #1;
        read_up  = 1'b0;
        write_up = 1'b0;
        up_oe    = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_data;
        int          exp_stall;
        int          exp_wb;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] wb_exp[4];
    logic [31:0] rdata;
    int          stalls, wb0, rd0, low0, nwb, nrd;
    bit          m_valid[64];
    bit          m_dirty[64];
    logic [21:0] m_tag[64];

    initial begin
        vecs[0] = '{1'b0, 32'h4010, 32'h0,  0, 32'h0000, 6,  0};
        vecs[1] = '{1'b0, 32'h4018, 32'h0,  0, 32'h2222, 0,  0};
        vecs[2] = '{1'b1, 32'h4013, 32'd18, 0, 32'h0,    0,  0};
        vecs[3] = '{1'b0, 32'h4010, 32'h0,  0, 32'd18,   0,  0};
        vecs[4] = '{1'b0, 32'h0410, 32'h0,  4, 32'hAAAA, 19, 4};
        vecs[5] = '{1'b0, 32'h4010, 32'h0,  0, 32'd18,   6,  0};
        wb_exp  = '{32'd18, 32'h1111, 32'h2222, 32'h3333};

        #3;
        check("reset read_mem", {31'b0, read_mem}, 32'h0);
        check("reset write_mem", {31'b0, write_mem}, 32'h0);
        check("reset addr_mem", addr_mem, 32'h0);
        check("reset stall_up", {31'b0, stall_up}, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        #2;
        check("idle stall_up", {31'b0, stall_up}, 32'h0);
        check("idle read_mem", {31'b0, read_mem}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            if (aborted) break;
            mem_lat = vecs[i].lat;
            do_op(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, stalls, wb0, rd0,
                  low0);
            nwb = wb_addr_q.size() - wb0;
            nrd = rd_addr_q.size() - rd0;
            check($sformatf("vec%0d stall cycles", i), stalls, vecs[i].exp_stall);
            check($sformatf("vec%0d writeback beats", i), nwb, vecs[i].exp_wb);
            check($sformatf("vec%0d fill beats", i), nrd, (vecs[i].exp_stall > 0) ? 4 : 0);
            if (!vecs[i].wr) check($sformatf("vec%0d read data", i), rdata, vecs[i].exp_data);
            if (nrd == 4) begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("vec%0d fill addr %0d", i, k), rd_addr_q[rd0 + k],
                          {vecs[i].addr[31:4], 4'b0} + 32'(4 * k));
            end
            if (vecs[i].exp_wb == 4 && nwb == 4) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("vec%0d wb addr %0d", i, k), wb_addr_q[wb0 + k],
                          32'h4010 + 32'(4 * k));
                    check($sformatf("vec%0d wb data %0d", i, k), wb_data_q[wb0 + k], wb_exp[k]);
                end
            end
        end

        // Reset in the middle of a fill must abort the transfer and drop all memory strobes.
        if (!aborted) begin
            mem_lat    = 0;
            rand_ready = 1'b0;
            @(negedge clk);
            #1;
            addr_up = 32'h8020;
            read_up = 1'b1;
            repeat (3) @(negedge clk);
            #1;
            check("mid-fill read_mem before reset", {31'b0, read_mem}, 32'h1);
            reset   = 1'b0;
            read_up = 1'b0;
            #1;
            check("reset read_mem drop", {31'b0, read_mem}, 32'h0);
            check("reset write_mem drop", {31'b0, write_mem}, 32'h0);
            check("reset addr_mem clear", addr_mem, 32'h0);
            check("reset stall_up clear", {31'b0, stall_up}, 32'h0);
            repeat (2) @(negedge clk);
            #1;
            reset = 1'b1;
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 1'b0;
                m_dirty[i] = 1'b0;
                m_tag[i]   = '0;
            end
            shadow = mem;
            do_op(1'b0, 1'b1, 32'h8020, 32'h0, rdata, stalls, wb0, rd0, low0);
            check("after reset 0x8020 misses", stalls, 6);
            check("after reset 0x8020 data", rdata, mem_rd(32'h8020));
            do_op(1'b0, 1'b1, 32'h4010, 32'h0, rdata, stalls, wb0, rd0, low0);
            check("after reset 0x4010 misses", stalls, 6);
            check("after reset 0x4010 data", rdata, 32'd18);
            m_valid[2] = 1'b1;
            m_tag[2]   = 22'h20;
            m_valid[1] = 1'b1;
            m_tag[1]   = 22'h10;
        end

        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, wa, wd;
            logic [31:0] old_line[4];
            logic [5:0]  idx;
            logic [21:0] tg;
            bit          wr, rd, hit;
            int          exp_wb, exp_stall;
            if (aborted) break;
            tg  = 22'($urandom_range(1, 3));
            idx = 6'($urandom_range(0, 3));
            a   = {tg, idx, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            wa  = {a[31:2], 2'b00};
            wr  = ($urandom_range(0, 9) < 4);
            rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            wd  = $urandom;
            mem_lat = $urandom_range(0, 2);
            hit    = m_valid[idx] && (m_tag[idx] == tg);
            exp_wb = (!hit && m_valid[idx] && m_dirty[idx]) ? 4 : 0;
            for (int k = 0; k < 4; k++)
                old_line[k] = shadow_rd({m_tag[idx], idx, 2'(k), 2'b00});
            exp_stall = hit ? 0 : ((exp_wb == 4) ? 11 : 6);
            do_op(wr, rd, a, wd, rdata, stalls, wb0, rd0, low0);
            nwb = wb_addr_q.size() - wb0;
            check($sformatf("rand%0d stall cycles", n), stalls,
                  exp_stall + (low_cycles - low0));
            check($sformatf("rand%0d writeback beats", n), nwb, exp_wb);
            if (exp_wb == 4 && nwb == 4) begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("rand%0d wb data %0d", n, k), wb_data_q[wb0 + k], old_line[k]);
            end
            if (!hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_dirty[idx] = 1'b0;
            end
            if (wr) begin
                shadow[wa]   = wd;
                m_dirty[idx] = 1'b1;
            end else begin
                check($sformatf("rand%0d read data @%08h", n, a), rdata, shadow_rd(wa));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
